// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared constants, station indices and FSM states for the dispatch controller.
package dispatch_pkg;
   localparam int INST_W  = 116;
   localparam int ENTRY_W = INST_W + 3;
   localparam int DC_LO   = 71;
   localparam int DC_HI   = 72;
   localparam int RS_ALU  = 0;
   localparam int RS_BR   = 1;
   localparam int RS_LSU  = 2;
   localparam int RS_FP   = 3;
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SYS} state_e;
endpackage

// File: rtl/dispatch_controller_if.sv
// dispatch_controller_if: decode-side, station-side and trap-unit signals of the dispatch controller.
interface dispatch_controller_if #(
   parameter int DEPTH  = 4,
   parameter int INST_W = 116
);
   logic                    in_valid;
   logic                    in_ready;
   logic [INST_W-1:0]       in_inst;
   logic                    in_fence;
   logic                    in_ecall;
   logic                    in_ebreak;
   logic [3:0]              rs_valid;
   logic [3:0]              rs_ready;
   logic [INST_W-1:0]       rs_inst;
   logic [3:0]              rs_empty;
   logic                    sys_req;
   logic                    sys_cause;
   logic                    sys_ack;
   logic [$clog2(DEPTH):0]  count;
   modport master (
      input  in_valid, in_inst, in_fence, in_ecall, in_ebreak, rs_ready, rs_empty, sys_ack,
      output in_ready, rs_valid, rs_inst, sys_req, sys_cause, count
   );
   modport slave (
      output in_valid, in_inst, in_fence, in_ecall, in_ebreak, rs_ready, rs_empty, sys_ack,
      input  in_ready, rs_valid, rs_inst, sys_req, sys_cause, count
   );
endinterface

// File: rtl/dispatch_fifo.sv
// dispatch_fifo: register-array FIFO with synchronous clear; head reads zero when empty.
module dispatch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 119
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [W-1:0]           data_i,
   output logic [W-1:0]           head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (clr_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   always_ff @(posedge clk)
      if (push_i) mem_q[wr_q] <= data_i;
   assign count_o = cnt_q;
   assign full_o  = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign head_o  = empty_o ? '0 : mem_q[rd_q];
endmodule

// File: rtl/dispatch_controller.sv
// dispatch_controller: steers buffered instructions to four stations, serializing fence/ecall/ebreak.
// Define DISPATCH_BYPASS_EN to let a normal instruction skip an empty FIFO in the same cycle.
module dispatch_controller #(
   parameter int DEPTH  = 4,
   parameter int INST_W = 116
) (
   input logic                   clk,
   input logic                   rst_n,
   input logic                   flush,
   dispatch_controller_if.master bus
);
   import dispatch_pkg::*;
   localparam int EW = INST_W + 3;
   state_e            state_q, state_d;
   logic [EW-1:0]     head;
   logic [INST_W-1:0] h_inst;
   logic [1:0]        h_idx;
   logic              h_ecall, h_ebreak, h_ser, empty, full, push, pop, byp, byp_take;
   logic [3:0]        byp_vec;
   assign h_inst   = head[INST_W-1:0];
   assign h_idx    = h_inst[DC_HI:DC_LO];
   assign h_ecall  = head[INST_W+1];
   assign h_ebreak = head[INST_W+2];
   assign h_ser    = |head[EW-1:INST_W];
`ifdef DISPATCH_BYPASS_EN
   logic [1:0] in_idx;
   assign in_idx   = bus.in_inst[DC_HI:DC_LO];
   assign byp      = state_q == ST_RUN && empty && bus.in_valid && !flush &&
                     !(bus.in_fence || bus.in_ecall || bus.in_ebreak);
   assign byp_vec  = byp ? 4'b0001 << in_idx : 4'b0000;
   assign byp_take = |(byp_vec & bus.rs_ready);
`else
   assign byp      = 1'b0;
   assign byp_vec  = 4'b0000;
   assign byp_take = 1'b0;
`endif
   // A full FIFO refuses pushes even when the head pops in the same cycle.
   assign push          = bus.in_valid && !full && !flush && !byp_take;
   assign bus.in_ready  = !full;
   assign bus.rs_inst   = byp ? bus.in_inst : h_inst;
   assign bus.rs_valid  = byp_vec | ((state_q == ST_RUN && !empty && !h_ser) ? 4'b0001 << h_idx : 4'b0000);
   assign bus.sys_req   = state_q == ST_SYS;
   assign bus.sys_cause = bus.sys_req && h_ebreak;
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      if (flush) state_d = ST_RUN;
      else if (state_q == ST_RUN) begin
         if (!empty && h_ser) state_d = ST_DRAIN;
         else if (!empty) pop = bus.rs_ready[h_idx];
      end else if (state_q == ST_DRAIN) begin
         if (&bus.rs_empty && (h_ecall || h_ebreak)) state_d = ST_SYS;
         else if (&bus.rs_empty) begin
            pop     = 1'b1;
            state_d = ST_RUN;
         end
      end else if (state_q == ST_SYS && bus.sys_ack) begin
         pop     = 1'b1;
         state_d = ST_RUN;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= ST_RUN;
      else state_q <= state_d;
   dispatch_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (flush),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  ({bus.in_ebreak, bus.in_ecall, bus.in_fence, bus.in_inst}),
      .head_o  (head),
      .count_o (bus.count),
      .full_o  (full),
      .empty_o (empty)
   );
endmodule

// File: doc/dispatch_controller.md
# dispatch_controller

Sequences decomposed instructions from the decode/rename stage into the four reservation stations. Buffers the 116-bit decomposed instruction word in a small FIFO and steers the head entry to the station selected by its dispatch_control field, using a valid/ready handshake. Serializes fence, ecall and ebreak: it drains all stations first, and hands system instructions to the trap unit. Sits between instruction_decompose and the reservation stations.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- INST_W, 116, decomposed word width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush (branch mispredict/trap)
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  FIFO can accept
- in_inst  in  INST_W  {memdata[115:84], ctrl[83:71], rs2_vt[70:39], s2_valid[38], rs1_vt[37:6], s1_valid[5], rd[4:0]}
- in_fence, in_ecall, in_ebreak  in  1 each  serializing flags from control
- rs_valid  out  4  one-hot dispatch strobe, index = dispatch_control
- rs_ready  in  4  per-station space available
- rs_inst  out  INST_W  head instruction word, shared by all stations
- rs_empty  in  4  per-station fully idle
- sys_req  out  1  system instruction pending at trap unit
- sys_cause  out  1  0 = ecall, 1 = ebreak
- sys_ack  in  1  trap unit accepted the request
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- dispatch_control = in_inst[72:71]: 00 ALU, 01 branch, 10 LSU, 11 FP. The block does not inspect other fields.
- FIFO entry = {ebreak, ecall, fence, inst}. Push on in_valid & in_ready. in_ready = (count != DEPTH); there is no push into a full FIFO even if a pop occurs in the same cycle.
- FSM states: RUN, DRAIN, SYS.
- RUN, head normal: rs_valid[head idx] = 1. Pop on rs_valid & rs_ready at that index.
- RUN, head fence/ecall/ebreak: rs_valid = 0. Go to DRAIN.
- DRAIN: rs_valid = 0, no pop. When rs_empty == 4'b1111:
  - fence: pop it without dispatching, go to RUN.
  - ecall/ebreak: go to SYS.
- SYS: sys_req = 1, sys_cause from entry. On sys_ack: pop, go to RUN. If sys_ack is asserted while in RUN or DRAIN, it is ignored.
- Precedence when several flags are set: ebreak > ecall > fence.
- flush: clears FIFO (count = 0), state = RUN, drops sys_req, and blocks any push that cycle. flush has priority over all other events.
- rs_inst = head instruction word, undefined (zero) when empty. Pointers wrap modulo DEPTH.

## Timing
- Reset (rst_n low, asynchronous): count = 0, state RUN, rs_valid = 0, sys_req = 0, sys_cause = 0, in_ready = 1, rs_inst = 0.
- Push in cycle N → dispatch-eligible in cycle N+1 (without bypass).
- At most one push and one pop per cycle. Simultaneous push and pop leaves count unchanged.
- A fence at the head leaves DRAIN one cycle after rs_empty reads all-ones. Back-to-back normal entries dispatch one per cycle while rs_ready is held high.
- rs_valid and sys_req depend only on registered state plus rs_ready/rs_empty. rs_valid never depends on rs_ready, so there is no combinational loop with the stations.
- Reset or flush mid-DRAIN/SYS returns to RUN the next edge. A lost sys_ack is not retried.

## Configuration
- DISPATCH_BYPASS_EN defined: in RUN, with the FIFO empty, a normal in_inst is presented on rs_inst/rs_valid in the same cycle. If the target rs_ready = 1, it is consumed without a push (zero-cycle latency). Otherwise it is pushed normally. Serializing instructions never bypass.
- Not defined: every instruction passes through the FIFO, with a minimum latency of 1 cycle.

## Structure
- dispatch_pkg: field position constants (DC_LO = 71, DC_HI = 72), station index constants (RS_ALU, RS_BR, RS_LSU, RS_FP), FSM state enum, and the entry-width constant INST_W+3.
- Sub-module dispatch_fifo: parameterized register-array FIFO exposing push/pop/head/count/full/empty, with synchronous clear driven by flush. The controller FSM and steering stay in dispatch_controller.

## Test plan
- Reset then push 4 ALU words (dispatch_control = 00) with rs_ready = 4'b0001 → rs_valid = 0001 on cycles 1–4 after the first push, count returns to 0, in_ready stays 1.
- Fill to DEPTH with rs_ready = 0 → in_ready = 0, count = 4. Raise rs_ready[2] for LSU heads (10) → one pop per cycle, in_ready = 1 the cycle after the first pop.
- Enqueue ALU, fence, ALU with rs_empty = 4'b1110 → second ALU held, no rs_valid. Set rs_empty = 1111 → fence popped silently, second ALU dispatches the following cycle.
- Enqueue ebreak with stations empty → sys_req = 1, sys_cause = 1. Hold sys_ack low 5 cycles, then pulse → entry popped, state RUN, sys_req = 0 next cycle.
- count = 3 with state SYS, then assert flush with in_valid = 1 → count = 0, sys_req = 0, no push. Next cycle a push is accepted.
- With DISPATCH_BYPASS_EN, empty FIFO, FP word (11), rs_ready = 1000 → rs_valid = 1000 in the same cycle as in_valid, count stays 0.
